aes_round_tail: RTL
===================

AES_ROUND_TAIL -- requirements
Module: aes_round_tail

Interface
REQ-001 The block SHALL have one parameter: SKID, default 1; 1 selects a 2-entry skid buffer with registered in_ready, 0 selects a single output register with in_ready = !out_valid || out_ready.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-006 The block SHALL have port in_state, input, 128 bits: post-SubBytes state; [127:120] is byte 0; byte i is row i%4, column i/4.
REQ-007 The block SHALL have port in_round_key, input, 128 bits: the round key, in the same byte order as in_state.
REQ-008 The block SHALL have port in_last_round, input, 1 bit: when set, MixColumns is skipped for this beat.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the output beat.
REQ-011 The block SHALL have port out_state, output, 128 bits: the round result.
REQ-012 The block SHALL have port out_last_round, output, 1 bit: in_last_round carried with its beat.

Function
REQ-013 An input transfer SHALL occur on a clock edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-014 The result SHALL be out_state = AddRoundKey(MixColumns(ShiftRows(in_state))), or AddRoundKey(ShiftRows(in_state)) when in_last_round = 1.
REQ-015 ShiftRows SHALL rotate row r left by r byte positions (r = 0..3) across the columns.
REQ-016 MixColumns SHALL use the FIPS-197 matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8) with reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00), truncated to 8 bits.
REQ-017 AddRoundKey SHALL be a bitwise XOR of the full 128 bits.
REQ-018 Latency SHALL be exactly 1 cycle: a beat accepted at edge N SHALL present out_valid = 1 after edge N when the buffer was empty.
REQ-019 Throughput SHALL be one beat per cycle while out_ready = 1.
REQ-020 While out_valid = 1 && out_ready = 0, out_state and out_last_round SHALL hold stable and out_valid SHALL remain 1.
REQ-021 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-022 With SKID = 1, in_ready SHALL be a register output, 1 when fewer than 2 entries are occupied after the current edge.
REQ-023 With SKID = 1, a full buffer SHALL drive in_ready = 0.
REQ-024 With SKID = 1, simultaneous input and output transfers SHALL leave occupancy unchanged.
REQ-025 With SKID = 0, simultaneous input and output transfers on a full register SHALL replace the contents in the same edge.
REQ-026 in_state and in_round_key SHALL be ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-027 While rst = 1: out_valid = 0, in_ready = 0, buffer occupancy = 0, out_state = 0, out_last_round = 0.
REQ-028 in_ready SHALL become 1 on the first clock edge after rst deasserts.
REQ-029 Asserting rst mid-operation SHALL discard all buffered beats immediately, without waiting for a clock edge.

Structure
REQ-030 Package aes_pkg SHALL hold the xtime function, the MixColumns coefficients, and the byte/row/column index helpers.
REQ-031 Sub-module aes_mix_column SHALL be purely combinational (32 bits in, 32 bits out) and SHALL be instantiated 4 times.
REQ-032 ShiftRows and AddRoundKey SHALL be written as combinational logic in the top module.
REQ-033 Registers SHALL exist only in the skid/output buffer.

Verification
REQ-034 FIPS-197 round 1: in_state = d42711aee0bf98f1b8b45de51e415230, key = a0fafe1788542cb123a339392a6c7605, last = 0 -> out_state = a49c7ff2689f352b6b5bea43026a5049 exactly 1 cycle later.
REQ-035 Same in_state, key = 0, last = 1 -> out_state = d4bf5d30e0b452aeb84111f11e2798e5 and out_last_round = 1.
REQ-036 aes_mix_column unit test: input column db135345 -> 8e4da1bc; input column f20a225c -> 9fdc589d.
REQ-037 Backpressure: stream 8 beats with random out_ready stalls -> output order and values match the reference model, out_state stable during stalls, in_ready = 0 only when the buffer is full (SKID = 1).
REQ-038 Reset: assert rst with 2 beats buffered -> out_valid = 0 asynchronously; after release, in_ready = 1 at the next edge and no stale beat appears.
REQ-039 Continuous out_ready = 1 with back-to-back in_valid for 16 cycles -> 16 outputs on consecutive cycles, for both SKID = 0 and SKID = 1.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES round-tail definitions:
//   - beat_t        : one buffered beat (round result + last-round flag)
//   - MIX_COEF      : FIPS-197 MixColumns matrix coefficients
//   - xtime         : GF(2^8) multiply-by-2, reduction polynomial 0x11B
//   - gf_mul_coef   : multiply by a MixColumns coefficient (1, 2 or 3)
//   - byte_row / byte_col / byte_idx / get_byte : state byte addressing,
//     byte 0 at [127:120], byte i sits at row i%4, column i/4
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int N_ROWS  = 4;
  localparam int N_COLS  = 4;
  localparam int N_BYTES = 16;

  typedef logic [1:0] coef_t;

  localparam coef_t MIX_COEF [N_ROWS][N_COLS] = '{
    '{2'd2, 2'd3, 2'd1, 2'd1},
    '{2'd1, 2'd2, 2'd3, 2'd1},
    '{2'd1, 2'd1, 2'd2, 2'd3},
    '{2'd3, 2'd1, 2'd1, 2'd2}
  };

  typedef struct packed {
    logic         last;
    logic [127:0] state;
  } beat_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_coef(input coef_t coef, input logic [7:0] b);
    case (coef)
      2'd1:    return b;
      2'd2:    return xtime(b);
      2'd3:    return xtime(b) ^ b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int byte_row(input int i);
    return i % N_ROWS;
  endfunction

  function automatic int byte_col(input int i);
    return i / N_ROWS;
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return col * N_ROWS + row;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127 - 8*i -: 8];
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// ---------------------------------------------------------------------------
// aes_mix_column
// Purely combinational MixColumns on one 32-bit column.
//   col_in  [31:0] : column, row 0 in [31:24]
//   col_out [31:0] : mixed column, same byte order
// ---------------------------------------------------------------------------
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        col_out[31 - 8*r -: 8] = col_out[31 - 8*r -: 8]
                               ^ gf_mul_coef(MIX_COEF[r][c], col_in[31 - 8*c -: 8]);
      end
    end
  end

endmodule

// File: rtl/aes_round_tail.sv
// ---------------------------------------------------------------------------
// aes_round_tail
// Tail of an AES encryption round: ShiftRows -> MixColumns (skipped on the
// last round) -> AddRoundKey, followed by a valid/ready output buffer.
//   SKID=1 : 2-entry skid buffer, in_ready comes straight from a flop
//   SKID=0 : single output register, in_ready = !out_valid || out_ready
// Ports:
//   clk, rst (async, active high)
//   in_valid / in_ready / in_state / in_round_key / in_last_round : input beat
//   out_valid / out_ready / out_state / out_last_round            : output beat
// ---------------------------------------------------------------------------
module aes_round_tail
  import aes_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_round_key,
  input  logic         in_last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last_round
);

  logic [127:0] shifted;
  logic [127:0] mixed;
  beat_t        beat_in;
  logic         push;
  logic         pop;

  // ShiftRows: output byte at (r, c) takes input byte at (r, (c + r) mod 4).
  always_comb begin
    shifted = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      shifted[127 - 8*i -: 8] =
        get_byte(in_state, byte_idx(byte_row(i), (byte_col(i) + byte_row(i)) % N_COLS));
    end
  end

  for (genvar col = 0; col < N_COLS; col++) begin : g_mix
    aes_mix_column u_mix (
      .col_in  (shifted[127 - 32*col -: 32]),
      .col_out (mixed  [127 - 32*col -: 32])
    );
  end

  always_comb begin
    beat_in.last  = in_last_round;
    beat_in.state = (in_last_round ? shifted : mixed) ^ in_round_key;
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  if (SKID != 0) begin : g_skid
    beat_t      head_q, head_d;
    beat_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;

    always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = beat_in;
          else                 tail_d = beat_in;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy stays put: the head leaves and the new beat takes its
          // place behind whatever is still queued.
          head_d = (count_q == 2'd1) ? beat_in : tail_q;
          tail_d = beat_in;
        end
        default: ;
      endcase
      in_ready_d = (count_d < 2'd2);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the payload registers are reset as well because out_state must
    // read zero while rst is high, not just be marked invalid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= 2'd0;
        in_ready_q <= 1'b0;
      end else begin
        head_q     <= head_d;
        tail_q     <= tail_d;
        count_q    <= count_d;
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (count_q != 2'd0);
    assign out_state      = head_q.state;
    assign out_last_round = head_q.last;

  end else begin : g_reg
    beat_t data_q, data_d;
    logic  valid_q, valid_d;
    logic  live_q, live_d;

    always_comb begin
      data_d  = push ? beat_in : data_q;
      valid_d = push ? 1'b1 : (pop ? 1'b0 : valid_q);
      live_d  = 1'b1;
    end

    // live_q holds in_ready low from reset until the first edge after
    // release, matching the registered-ready timing of the skid variant.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        live_q  <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        live_q  <= live_d;
      end
    end

    assign in_ready       = live_q && (!valid_q || out_ready);
    assign out_valid      = valid_q;
    assign out_state      = data_q.state;
    assign out_last_round = data_q.last;
  end

endmodule
